// File: rtl/signal_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_SRC log producers.
// Each grant sends an optional source-ID header byte and then the source's data byte.
module signal_tx_sched #(
  parameter int unsigned NUM_SRC       = 4,
  parameter bit          HEADER_EN     = 1'b1,
  parameter logic [3:0]  HDR_MARK      = 4'hA,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [NUM_SRC*8-1:0]   req_data,
  output logic [NUM_SRC-1:0]     ack,
  input  logic                   tx_ready,
  output logic                   tx_enable,
  output logic [7:0]             log_output,
  output logic                   busy,
  output logic [3:0]             last_src,
  output logic                   err_timeout
);

  localparam int unsigned      CNT_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         ptr;
  logic [3:0]         ptr_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         data_q;
  logic [7:0]         data_next;
  logic               hdr_pend;
  logic               hdr_pend_next;
  logic [NUM_SRC-1:0] ack_next;
  logic               tx_enable_next;
  logic [7:0]         log_output_next;
  logic               busy_next;
  logic [3:0]         last_src_next;
  logic               err_next;

  logic               grant_any;
  logic [3:0]         win;
  logic [NUM_SRC-1:0] win_onehot;
  logic [7:0]         win_data;

  assign cnt_inc = cnt + CNT_W'(1);

  // Round-robin pick: first requester at or above ptr, else wrap to the lowest requester.
  always_comb begin
    grant_any  = 1'b0;
    win        = '0;
    win_onehot = '0;
    win_data   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!grant_any && req[i] && (4'(i) >= ptr)) begin
        grant_any     = 1'b1;
        win           = 4'(i);
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!grant_any && req[i]) begin
        grant_any     = 1'b1;
        win           = 4'(i);
        win_onehot[i] = 1'b1;
        win_data      = req_data[8*i +: 8];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      data_q      <= '0;
      hdr_pend    <= 1'b0;
      ack         <= '0;
      tx_enable   <= 1'b0;
      log_output  <= '0;
      busy        <= 1'b0;
      last_src    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cnt         <= cnt_next;
      data_q      <= data_next;
      hdr_pend    <= hdr_pend_next;
      ack         <= ack_next;
      tx_enable   <= tx_enable_next;
      log_output  <= log_output_next;
      busy        <= busy_next;
      last_src    <= last_src_next;
      err_timeout <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tx_ready && grant_any) state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_ready)               state_next = WAIT_DONE;
        else if (cnt_inc == CNT_MAX) state_next = IDLE;
      end
      WAIT_DONE: begin
        if (tx_ready) state_next = hdr_pend ? LAUNCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of outputs and datapath registers.
  always_comb begin
    ack_next        = '0;
    tx_enable_next  = 1'b0;
    log_output_next = log_output;
    busy_next       = (state_next != IDLE);
    last_src_next   = last_src;
    err_next        = err_timeout;
    ptr_next        = ptr;
    cnt_next        = cnt;
    data_next       = data_q;
    hdr_pend_next   = hdr_pend;
    case (state)
      IDLE: begin
        if (tx_ready && grant_any) begin
          ack_next        = win_onehot;
          last_src_next   = win;
          ptr_next        = (win == LAST_IDX) ? 4'd0 : win + 4'd1;
          data_next       = win_data;
          hdr_pend_next   = HEADER_EN;
          tx_enable_next  = 1'b1;
          log_output_next = HEADER_EN ? {HDR_MARK, win} : win_data;
          cnt_next        = '0;
        end
      end
      WAIT_START: begin
        if (tx_ready) begin
          cnt_next = cnt_inc;
          // Transmitter never started: flag it and abandon the rest of the frame.
          if (cnt_inc == CNT_MAX) begin
            err_next      = 1'b1;
            hdr_pend_next = 1'b0;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_ready && hdr_pend) begin
          tx_enable_next  = 1'b1;
          log_output_next = data_q;
          hdr_pend_next   = 1'b0;
          cnt_next        = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_signal_tx_sched.sv
// Bench for signal_tx_sched: round-robin reference model with a byte scoreboard,
// a behavioural transmitter, directed corner cases and a randomized traffic phase.
module tb_signal_tx_sched;

  localparam int NS = 4;

  logic            clk        = 1'b0;
  logic            rst        = 1'b1;
  logic [NS-1:0]   req        = '0;
  logic [NS*8-1:0] req_data   = '0;
  logic [NS-1:0]   ack;
  logic            tx_ready   = 1'b1;
  logic            tx_enable;
  logic [7:0]      log_output;
  logic            busy;
  logic [3:0]      last_src;
  logic            err_timeout;

  logic [NS-1:0]   req0       = '0;
  logic [NS*8-1:0] req_data0  = '0;
  logic [NS-1:0]   ack0;
  logic            tx_ready0  = 1'b1;
  logic            tx_enable0;
  logic [7:0]      log_output0;
  logic            busy0;
  logic [3:0]      last_src0;
  logic            err_timeout0;

  int         checks  = 0;
  int         errors  = 0;
  int         tx_mode = 0;   // 0 normal, 1 never starts, 2 held busy
  int         tx_rem  = 0;
  int         m_ptr   = 0;
  int         ack_cnt = 0;
  int         mw;
  logic [7:0] mb;
  logic [7:0] exp_q[$];

  signal_tx_sched #(.NUM_SRC(NS), .HEADER_EN(1'b1), .HDR_MARK(4'hA), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_ready(tx_ready), .tx_enable(tx_enable), .log_output(log_output),
    .busy(busy), .last_src(last_src), .err_timeout(err_timeout)
  );

  signal_tx_sched #(.NUM_SRC(NS), .HEADER_EN(1'b0), .HDR_MARK(4'hA), .START_TIMEOUT(16)) dut_nohdr (
    .clk(clk), .rst(rst), .req(req0), .req_data(req_data0), .ack(ack0),
    .tx_ready(tx_ready0), .tx_enable(tx_enable0), .log_output(log_output0),
    .busy(busy0), .last_src(last_src0), .err_timeout(err_timeout0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Transmitter model: goes busy the cycle after a launch for a random frame time.
  always begin
    @(posedge clk); #3;
    if (rst) begin
      tx_ready = 1'b1;
      tx_rem   = 0;
    end else if (tx_mode == 2) begin
      tx_ready = 1'b0;
    end else if (tx_mode == 1) begin
      tx_ready = 1'b1;
    end else if (tx_enable && tx_ready) begin
      tx_ready = 1'b0;
      tx_rem   = $urandom_range(2, 10);
    end else if (tx_rem > 0) begin
      tx_rem--;
      if (tx_rem == 0) tx_ready = 1'b1;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Monitor: predict the winner from the round-robin rule, queue its bytes, match launches.
  always begin
    @(posedge clk); #1;
    if (rst) begin
      m_ptr = 0;
      exp_q.delete();
    end else begin
      if (ack != '0) begin
        ack_cnt++;
        mw = -1;
        for (int k = 0; k < NS; k++) begin
          if (mw < 0 && req[(m_ptr + k) % NS]) mw = (m_ptr + k) % NS;
        end
        check("grant_with_tx_ready", 32'(tx_ready), 32'd1);
        if (mw < 0) begin
          checks++;
          errors++;
          $display("FAIL grant_without_request: ack %0h req %0h", ack, req);
        end else begin
          check("ack_winner", 32'(ack), 32'(1 << mw));
          check("last_src", 32'(last_src), 32'(mw));
          check("ack_with_launch", 32'(tx_enable), 32'd1);
          mb = 8'(req_data >> (8 * mw));
          exp_q.push_back({4'hA, 4'(mw)});
          exp_q.push_back(mb);
          m_ptr = (mw + 1) % NS;
        end
      end
      if (tx_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: byte %0h", log_output);
        end else begin
          check("tx_byte", 32'(log_output), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One clock; requesters drop req the cycle after seeing their ack.
  task automatic tick(output logic [NS-1:0] dropped);
    @(posedge clk); #2;
    dropped = req & ack;
    req     = req & ~ack;
  endtask

  task automatic wait_ack(input string name, input logic [NS-1:0] want);
    logic [NS-1:0] dr;
    bit got;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(dr);
      if (ack != '0) begin
        got = 1'b1;
        check(name, 32'(ack), 32'(want));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within bound, got 0 want %0h", name, want);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    logic [NS-1:0] dr;
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      tick(dr);
      if (req == '0 && !busy && exp_q.size() == 0) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [NS-1:0] dr;
    logic [NS-1:0] prev;
    logic [7:0]    bytes[$];
    int            grants[$];
    int            lasts[$];
    int            exp_order[5];
    int            n;
    int            rem0;
    bit            done;
    bit            rose;
    logic [7:0]    b0;

    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) tick(dr);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_log_output", 32'(log_output), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_src", 32'(last_src), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_busy_nohdr", 32'(busy0), 32'd0);
    rst = 1'b0;
    tick(dr);

    // Single source with header.
    req_data[23:16] = 8'h5A;
    req[2] = 1'b1;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick(dr);
      if (ack != '0) begin
        n++;
        check("t1_ack", 32'(ack), 32'h4);
      end
      if (tx_enable) bytes.push_back(log_output);
      if (n > 0 && !busy && req == '0) done = 1'b1;
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_launches", 32'(bytes.size()), 32'd2);
    if (bytes.size() == 2) begin
      check("t1_header", 32'(bytes[0]), 32'hA2);
      check("t1_data", 32'(bytes[1]), 32'h5A);
    end

    // Header disabled: one launch carrying the data byte.
    req_data0[15:8] = 8'hFF;
    req0[1] = 1'b1;
    n = 0;
    rem0 = 0;
    rose = 1'b0;
    done = 1'b0;
    b0 = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick(dr);
      if (ack0 != '0) begin
        check("t3_ack", 32'(ack0), 32'h2);
        req0 = '0;
      end
      if (tx_enable0) begin
        n++;
        b0 = log_output0;
        tx_ready0 = 1'b0;
        rem0 = 4;
      end else if (rem0 > 0) begin
        rem0--;
        if (rem0 == 0) begin
          check("t3_busy_during_frame", 32'(busy0), 32'd1);
          tx_ready0 = 1'b1;
          rose = 1'b1;
        end
      end else if (rose) begin
        check("t3_busy_after_ready", 32'(busy0), 32'd0);
        done = 1'b1;
      end
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_launches", 32'(n), 32'd1);
    check("t3_byte", 32'(b0), 32'hFF);
    check("t3_last_src", 32'(last_src0), 32'd1);

    // Transmitter busy in IDLE: request must wait.
    tx_mode = 2;
    repeat (2) tick(dr);
    req_data[31:24] = 8'h3C;
    req[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(dr);
      check("t6_no_ack", 32'(ack), 32'd0);
    end
    tx_mode = 0;
    wait_ack("t6_ack", 4'b1000);
    wait_idle("t6_idle", 100);

    // Transmitter never starts: timeout, frame abandoned, scheduler keeps going.
    tx_mode = 1;
    req_data[15:8] = 8'h77;
    req[1] = 1'b1;
    wait_ack("t4_ack", 4'b0010);
    repeat (15) tick(dr);
    check("t4_err_not_yet", 32'(err_timeout), 32'd0);
    for (int c = 0; c < 6 && !err_timeout; c++) tick(dr);
    check("t4_err", 32'(err_timeout), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_data_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tx_mode = 0;
    req_data[7:0] = 8'h81;
    req[0] = 1'b1;
    wait_ack("t4_next_ack", 4'b0001);
    wait_idle("t4_next_idle", 100);
    check("t4_err_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of a frame.
    req_data[23:16] = 8'h66;
    req[2] = 1'b1;
    wait_ack("t5_ack", 4'b0100);
    repeat (2) tick(dr);
    check("t5_busy_mid_frame", 32'(busy), 32'd1);
    rst = 1'b1;
    req_data = 32'h43322110;
    req = 4'b1111;
    tick(dr);
    check("t5_tx_enable", 32'(tx_enable), 32'd0);
    check("t5_ack", 32'(ack), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err_cleared", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // All sources requesting: rotate 0,1,2,3,0.
    for (int c = 0; c < 300 && grants.size() < 5; c++) begin
      prev = req;
      tick(dr);
      if (ack != '0) begin
        for (int k = 0; k < NS; k++) if (ack[k]) grants.push_back(k);
        lasts.push_back(int'(last_src));
      end
      if (grants.size() < 5) begin
        for (int k = 0; k < NS; k++) if (!prev[k]) req[k] = 1'b1;
      end
    end
    check("t2_grant_count", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      check($sformatf("t2_grant%0d", k), 32'(grants[k]), 32'(exp_order[k]));
      check($sformatf("t2_last_src%0d", k), 32'(lasts[k]), 32'(exp_order[k]));
    end
    wait_idle("t2_idle", 400);

    // Random traffic against the reference model.
    ack_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      tick(dr);
      for (int k = 0; k < NS; k++) begin
        if (!req[k] && !dr[k] && $urandom_range(0, 3) == 0) begin
          req_data[8*k +: 8] = 8'($urandom);
          req[k] = 1'b1;
        end
      end
    end
    wait_idle("random_drain", 3000);
    check("random_grants_seen", 32'(ack_cnt > 15), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
